// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM for the 4-bit-opcode CPU datapath with memory-ready timeout and retire counter
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          opcode,
  input  logic                alu_lt,
  input  logic                alu_gt,
  input  logic                alu_eq,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                halted,
  output logic                bus_err,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [3:0] OP_A    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b0100;
  localparam logic [3:0] OP_BGT  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;
  state_t      state, state_nx;
  logic [3:0]  op_q;
  logic [7:0]  wait_cnt;
  logic        mem_wait, timeout, legal, is_branch, taken, retire_ev;
  assign mem_wait  = state == FETCH || state == MEM;
  // ready in the cycle the count sits at the limit still completes the access
  assign timeout   = mem_wait && !mem_ready && wait_cnt == 8'(MEM_TIMEOUT);
  assign legal     = opcode inside {OP_A, OP_LW, OP_SW, OP_BLT, OP_BGT, OP_BEQ, OP_JMP, OP_HALT};
  assign is_branch = op_q inside {OP_BLT, OP_BGT, OP_BEQ};
  assign taken     = (op_q == OP_BLT && alu_lt) || (op_q == OP_BGT && alu_gt) || (op_q == OP_BEQ && alu_eq);
  assign retire_ev = (state == DECODE && (opcode == OP_JMP || opcode == OP_HALT || !legal)) ||
                     (state == EXEC && is_branch) ||
                     (state == MEM && op_q == OP_SW && mem_ready) ||
                     state == WB;
  assign halted     = state == HALT;
  assign illegal_op = state == DECODE && !legal;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // datapath bookkeeping: latched opcode, memory wait counter, retire counter, sticky bus error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q     <= '0;
      wait_cnt <= '0;
      retired  <= '0;
      bus_err  <= 1'b0;
    end else begin
      op_q     <= state == DECODE ? opcode : op_q;
      wait_cnt <= mem_wait && !mem_ready ? wait_cnt + 8'd1 : 8'd0;
      retired  <= retired + RETIRE_W'(retire_ev);
      bus_err  <= bus_err | timeout;
    end
  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = FETCH;
      FETCH:   state_nx = timeout ? HALT : mem_ready ? DECODE : FETCH;
      DECODE:  state_nx = opcode == OP_HALT ? HALT : (opcode == OP_JMP || !legal) ? FETCH : EXEC;
      EXEC:    state_nx = op_q == OP_A ? WB : (op_q == OP_LW || op_q == OP_SW) ? MEM : FETCH;
      MEM:     state_nx = timeout ? HALT : !mem_ready ? MEM : op_q == OP_LW ? WB : FETCH;
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end
  // control strobes decoded from state and latched opcode
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        pc_write = mem_ready;
        ir_write = mem_ready;
      end
      DECODE: begin
        pc_write = opcode == OP_JMP;
        pc_src   = opcode == OP_JMP ? 2'b10 : 2'b00;
      end
      EXEC: begin
        alu_op    = op_q == OP_A ? 2'b10 : is_branch ? 2'b01 : 2'b00;
        alu_src_b = op_q == OP_LW || op_q == OP_SW;
        pc_write  = taken;
        pc_src    = taken ? 2'b01 : 2'b00;
      end
      MEM: begin
        mem_read  = op_q == OP_LW;
        mem_write = op_q == OP_SW;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = op_q == OP_A;
        mem_to_reg = op_q == OP_LW;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: instruction-level scoreboard bench for the multi-cycle sequencer
module tb_multicycle_sequencer;
  localparam int MT = 15;
  localparam logic [3:0] OP_A = 4'b0000, OP_LW = 4'b1000, OP_SW = 4'b1011, OP_BLT = 4'b0100;
  localparam logic [3:0] OP_BGT = 4'b0101, OP_BEQ = 4'b0110, OP_JMP = 4'b1100, OP_HALT = 4'b1111;
  localparam int PW = 14, PS = 12, IW = 11, MR = 10, MW = 9, ASB = 8, AOP = 6, RD = 5, M2R = 4, RW = 3, H = 2, BE = 1, IL = 0;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] opcode = '0;
  logic alu_lt = 1'b0, alu_gt = 1'b0, alu_eq = 1'b0, mem_ready = 1'b0;
  logic pc_write, ir_write, mem_read, mem_write, alu_src_b, reg_dst, mem_to_reg, reg_write, halted, bus_err, illegal_op;
  logic [1:0] pc_src, alu_op;
  logic [15:0] retired;
  logic pc_write_s, ir_write_s, mem_read_s, mem_write_s, alu_src_b_s, reg_dst_s, mem_to_reg_s, reg_write_s, halted_s, bus_err_s, illegal_op_s;
  logic [1:0] pc_src_s, alu_op_s;
  logic [2:0] retired_s;
  logic [14:0] obs;
  typedef struct packed { logic rdy; logic [14:0] exp; } step_t;
  step_t q[$];
  int n_cmp = 0, n_fail = 0, model_ret = 0;
  bit m_berr = 0;

  multicycle_sequencer #(.MEM_TIMEOUT(MT), .RETIRE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_lt(alu_lt), .alu_gt(alu_gt), .alu_eq(alu_eq),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .halted(halted), .bus_err(bus_err), .illegal_op(illegal_op), .retired(retired));

  multicycle_sequencer #(.MEM_TIMEOUT(MT), .RETIRE_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_lt(alu_lt), .alu_gt(alu_gt), .alu_eq(alu_eq),
    .mem_ready(mem_ready), .pc_write(pc_write_s), .pc_src(pc_src_s), .ir_write(ir_write_s), .mem_read(mem_read_s),
    .mem_write(mem_write_s), .alu_src_b(alu_src_b_s), .alu_op(alu_op_s), .reg_dst(reg_dst_s), .mem_to_reg(mem_to_reg_s),
    .reg_write(reg_write_s), .halted(halted_s), .bus_err(bus_err_s), .illegal_op(illegal_op_s), .retired(retired_s));

  assign obs = {pc_write, pc_src, ir_write, mem_read, mem_write, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, halted, bus_err, illegal_op};

  always #5 clk = ~clk;

  task automatic run_steps(input string tag);
    foreach (q[i]) begin
      mem_ready = q[i].rdy;
      @(negedge clk);
      n_cmp++;
      if (obs !== q[i].exp) begin
        n_fail++;
        $display("FAIL %s step %0d: strobes got %h expected %h", tag, i, obs, q[i].exp);
      end
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  task automatic check_ret(input string tag);
    n_cmp++;
    if (retired !== 16'(model_ret)) begin
      n_fail++;
      $display("FAIL %s retired: got %0d expected %0d", tag, retired, 16'(model_ret));
    end
    n_cmp++;
    if (retired_s !== 3'(model_ret)) begin
      n_fail++;
      $display("FAIL %s retired_small: got %0d expected %0d", tag, retired_s, 3'(model_ret));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== '0 || retired !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: strobes %h retired %0d expected 0/0", obs, retired);
    end
    rst_n = 1'b1;
    model_ret = 0;
    m_berr = 0;
    @(negedge clk);
    n_cmp++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: strobes got %h expected 0", obs);
    end
    @(posedge clk);
    #1;
  endtask

  // builds the expected cycle trace of one instruction from its semantics, then plays it
  task automatic run_instr(input logic [3:0] op, input logic lt, input logic gt, input logic eq,
                           input int wf, input int wm, input string tag);
    logic [14:0] e;
    bit legal, halt_now, taken;
    int r = 0;
    opcode = op;
    alu_lt = lt;
    alu_gt = gt;
    alu_eq = eq;
    legal = op inside {OP_A, OP_LW, OP_SW, OP_BLT, OP_BGT, OP_BEQ, OP_JMP, OP_HALT};
    halt_now = 0;
    e = '0;
    e[MR] = 1'b1;
    for (int i = 0; i < (wf > MT ? MT + 1 : wf); i++) q.push_back('{1'b0, e});
    if (wf > MT) begin
      halt_now = 1;
      m_berr = 1;
    end else begin
      e[PW] = 1'b1;
      e[IW] = 1'b1;
      q.push_back('{1'b1, e});
      e = '0;
      if (op == OP_JMP) begin
        e[PW] = 1'b1;
        e[PS+:2] = 2'b10;
        r = 1;
      end else if (op == OP_HALT) begin
        r = 1;
        halt_now = 1;
      end else if (!legal) begin
        e[IL] = 1'b1;
        r = 1;
      end
      q.push_back('{1'($urandom), e});
      if (legal && op != OP_JMP && op != OP_HALT) begin
        e = '0;
        if (op == OP_A) begin
          e[AOP+:2] = 2'b10;
          q.push_back('{1'($urandom), e});
          e = '0;
          e[RW] = 1'b1;
          e[RD] = 1'b1;
          q.push_back('{1'($urandom), e});
          r = 1;
        end else if (op == OP_LW || op == OP_SW) begin
          e[ASB] = 1'b1;
          q.push_back('{1'($urandom), e});
          e = '0;
          if (op == OP_LW) e[MR] = 1'b1;
          else e[MW] = 1'b1;
          for (int i = 0; i < (wm > MT ? MT + 1 : wm); i++) q.push_back('{1'b0, e});
          if (wm > MT) begin
            halt_now = 1;
            m_berr = 1;
          end else begin
            q.push_back('{1'b1, e});
            if (op == OP_LW) begin
              e = '0;
              e[RW] = 1'b1;
              e[M2R] = 1'b1;
              q.push_back('{1'($urandom), e});
            end
            r = 1;
          end
        end else begin
          taken = op == OP_BLT ? lt : op == OP_BGT ? gt : eq;
          e[AOP+:2] = 2'b01;
          e[PW] = taken;
          e[PS+:2] = taken ? 2'b01 : 2'b00;
          q.push_back('{1'($urandom), e});
          r = 1;
        end
      end
    end
    if (halt_now) begin
      e = '0;
      e[H] = 1'b1;
      e[BE] = m_berr;
      for (int i = 0; i < 4; i++) q.push_back('{1'($urandom), e});
    end
    run_steps(tag);
    model_ret += r;
    check_ret(tag);
  endtask

  task automatic test_reset();
    do_reset();
    check_ret("reset");
  endtask

  task automatic test_type_a();
    do_reset();
    run_instr(OP_A, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, "type_a");
  endtask

  task automatic test_lw_wait();
    run_instr(OP_LW, 1'b0, 1'b0, 1'b0, 0, 3, "lw_wait");
    run_instr(OP_SW, 1'b0, 1'b0, 1'b0, 2, 1, "sw_wait");
  endtask

  task automatic test_branch();
    run_instr(OP_BLT, 1'b1, 1'b0, 1'b0, 0, 0, "blt_taken");
    run_instr(OP_BLT, 1'b0, 1'b1, 1'b1, 0, 0, "blt_not");
    run_instr(OP_BGT, 1'b0, 1'b1, 1'b0, 0, 0, "bgt_taken");
    run_instr(OP_BGT, 1'b1, 1'b0, 1'b1, 0, 0, "bgt_not");
    run_instr(OP_BEQ, 1'b0, 1'b0, 1'b1, 0, 0, "beq_taken");
    run_instr(OP_BEQ, 1'b1, 1'b1, 1'b0, 0, 0, "beq_not");
  endtask

  task automatic test_jmp_illegal();
    run_instr(OP_JMP, 1'b0, 1'b0, 1'b0, 0, 0, "jmp");
    run_instr(4'b0011, 1'b1, 1'b1, 1'b1, 0, 0, "illegal");
    run_instr(OP_A, 1'b0, 1'b0, 1'b0, 1, 0, "after_illegal");
  endtask

  task automatic test_timeouts();
    do_reset();
    run_instr(OP_JMP, 1'b0, 1'b0, 1'b0, 0, 0, "pre_timeout");
    run_instr(OP_A, 1'b0, 1'b0, 1'b0, MT + 1, 0, "fetch_timeout");
    do_reset();
    run_instr(OP_A, 1'b0, 1'b0, 1'b0, MT, 0, "fetch_ready_at_limit");
    run_instr(OP_SW, 1'b0, 1'b0, 1'b0, 0, MT, "mem_ready_at_limit");
    run_instr(OP_LW, 1'b0, 1'b0, 1'b0, 0, MT + 1, "mem_timeout");
  endtask

  task automatic test_halt();
    do_reset();
    run_instr(OP_HALT, 1'b1, 1'b1, 1'b1, 0, 0, "halt");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) run_instr(OP_JMP, 1'b0, 1'b0, 1'b0, 0, 0, "wrap_fill");
    run_instr(OP_BEQ, 1'b0, 1'b0, 1'b1, 0, 0, "wrap_a");
    run_instr(OP_A, 1'b0, 1'b0, 1'b0, 0, 0, "wrap_b");
    n_cmp++;
    if (retired_s !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_zero: retired_small got %0d expected 0", retired_s);
    end
  endtask

  task automatic test_abort();
    do_reset();
    run_instr(OP_JMP, 1'b0, 1'b0, 1'b0, 0, 0, "abort_pre");
    opcode = OP_SW;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_mem: mem_write got %b expected 1", mem_write);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0 || retired !== '0) begin
      n_fail++;
      $display("FAIL abort_reset: strobes %h retired %0d expected 0/0", obs, retired);
    end
    do_reset();
    run_instr(OP_A, 1'b0, 1'b0, 1'b0, 0, 0, "after_abort");
  endtask

  task automatic test_random();
    logic [3:0] op;
    int wf, wm;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 14));
      wf = ($urandom % 8 == 0) ? $urandom_range(0, MT) : $urandom_range(0, 2);
      wm = ($urandom % 8 == 0) ? $urandom_range(0, MT) : $urandom_range(0, 2);
      run_instr(op, 1'($urandom), 1'($urandom), 1'($urandom), wf, wm, "random");
    end
  endtask

  initial begin
    test_reset();
    test_type_a();
    test_lw_wait();
    test_branch();
    test_jmp_illegal();
    test_timeouts();
    test_halt();
    test_wrap();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
